rom_sequencer: RTL and testbench
================================

# rom_sequencer

Parametrised successor to the single-pass ROM-to-LCD controller. It walks a programmable address window of the character ROM and presents each entry to the LCD driver with a busy-flag handshake. It adds one-shot and loop modes, runtime start/end addresses, an abort input, a sticky handshake timeout and a pass counter. It sits between the character ROM (address side) and the LCD module (`lcd_busy` / `data_ready` side).

## Interface
- `ADDR_W`, 4: ROM address width; `rom_address` wraps modulo 2^ADDR_W.
- `TIMEOUT_CYCLES`, 1_000_000: maximum cycles in PRESENT waiting for `lcd_busy` to rise. 0 disables the timeout. Must fit in 32 bits.
- `PASS_W`, 8: width of the saturating pass counter.
- `clock`, in, 1: single system clock, rising edge.
- `internal_reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle pulse that begins a run. Honoured only in IDLE, DONE or ERROR.
- `abort`, in, 1: level; forces IDLE.
- `loop_mode`, in, 1: sampled at `start`. 1 means restart at `start_addr` after `end_addr`.
- `start_addr`, in, ADDR_W: first address, sampled at `start`.
- `end_addr`, in, ADDR_W: last address presented, sampled at `start`.
- `lcd_busy`, in, 1: LCD module busy flag.
- `rom_address`, out, ADDR_W: current ROM address, registered.
- `data_ready`, out, 1: ROM output valid for the LCD, registered.
- `active`, out, 1: high in WAIT_FREE or PRESENT.
- `done`, out, 1: high in DONE (one-shot run complete).
- `timeout_err`, out, 1: sticky; high in ERROR.
- `pass_count`, out, PASS_W: completed passes, saturating at all-ones.

## Operation
- All outputs are registered. Reset values: `rom_address`=0, `data_ready`=0, `active`=0, `done`=0, `timeout_err`=0, `pass_count`=0. State resets to IDLE.
- IDLE, DONE or ERROR with `start`=1:
  - Latch `start_addr`, `end_addr` and `loop_mode`.
  - `rom_address`←`start_addr`; clear `done`, `timeout_err` and `pass_count`.
  - Go to WAIT_FREE.
- WAIT_FREE: wait for `lcd_busy`=0. This blocks the first character while the LCD is still initialising (busy high). On `lcd_busy`=0, set `data_ready`←1, clear the watchdog and go to PRESENT.
- PRESENT: hold `data_ready`=1 and `rom_address` stable. On `lcd_busy`=1, set `data_ready`←0, then:
  - If `rom_address`≠latched end: `rom_address`←`rom_address`+1, modulo 2^ADDR_W, and go to WAIT_FREE.
  - Else increment `pass_count` (saturating), then:
    - If loop mode: `rom_address`←latched start, go to WAIT_FREE.
    - Otherwise: go to DONE, `done`←1, `rom_address`←0.
- Window arithmetic:
  - end < start wraps through 2^ADDR_W−1 to 0, then on to end.
  - start = end presents exactly one entry per pass.
  - The full window is start=0, end=2^ADDR_W−1 (2^ADDR_W entries).
- Timeout: if PRESENT lasts TIMEOUT_CYCLES cycles without `lcd_busy` rising, go to ERROR. ERROR sets `data_ready`←0 and `timeout_err`←1; `rom_address` is held for diagnosis.
- Priority when events coincide: `internal_reset` > `abort` > timeout > `lcd_busy` rise > `start`. `abort` from any state → IDLE next cycle with `data_ready`=0, `active`=0, `done`=0. `timeout_err` and `rom_address` are held.
- A `start` pulse in WAIT_FREE or PRESENT is ignored. Changes to `start_addr`/`end_addr`/`loop_mode` mid-run have no effect.

## Timing
- `start` at edge N: WAIT_FREE and `rom_address`=start_addr after N. If `lcd_busy`=0, `data_ready`=1 after N+1.
- `lcd_busy` falls (sampled at edge M): `data_ready`=1 after M; `rom_address` has been stable since at least edge M−1.
- `lcd_busy` rises (sampled at edge K): `data_ready`=0 and the next address are both visible after K.
- Minimum per-character period: 2 cycles, given instant busy toggling.
- Timeout: entering PRESENT at edge P with busy never rising → `timeout_err`=1 after edge P+TIMEOUT_CYCLES.
- Asynchronous reset takes effect immediately on assertion. The first transition occurs on the first `clock` edge after deassertion.

## Structure
- Package `rom_seq_pkg`:
  - `typedef enum logic [2:0] {IDLE, WAIT_FREE, PRESENT, DONE, ERROR} rom_seq_state_t`.
  - Shared localparam for the watchdog counter width, `$clog2(TIMEOUT_CYCLES+1)`.
- Sub-module `busy_watchdog`: clear/enable/expired counter parameterised by TIMEOUT_CYCLES. It is tied off when TIMEOUT_CYCLES=0.

## Test plan
- ADDR_W=4, start=0, end=15, one-shot, LCD model busy for 3 cycles per character:
  - 16 `data_ready` pulses at addresses 0..15.
  - Then `done`=1, `pass_count`=1, `rom_address`=0.
- start=14, end=1, loop, run 2 passes: address sequence 14,15,0,1,14,15,0,1; `pass_count`=2; `done` stays 0.
- `lcd_busy` held 1 for 50 cycles after reset, then `start`: no `data_ready` until busy falls; the first address presented is `start_addr`.
- TIMEOUT_CYCLES=8, LCD stuck low in PRESENT at address 5:
  - `timeout_err`=1 exactly 8 cycles after PRESENT entry; `data_ready`=0; `rom_address`=5.
  - A new `start` clears `timeout_err`.
- `abort` asserted in the same cycle as a `lcd_busy` rise at address 3: IDLE next cycle, `data_ready`=0, `rom_address` stays 3.
- `internal_reset` pulsed mid-PRESENT, asynchronously between edges: all outputs return to their reset values before the next `clock` edge.

Source files
------------

// File: rtl/rom_sequencer_pkg.sv
// Shared types and helpers for the ROM-to-LCD sequencer.
// Holds the FSM state encoding and the watchdog counter sizing.
package rom_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FREE,
    PRESENT,
    DONE,
    ERROR
  } rom_seq_state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'd1_000_000;

  // Counter must be able to hold the timeout value itself; a disabled watchdog still needs 1 bit.
  function automatic int wdog_width(input int unsigned timeout_cycles);
    if (timeout_cycles == 0) begin
      return 1;
    end
    return $clog2(longint'(timeout_cycles) + 64'd1);
  endfunction

  localparam int WDOG_W = wdog_width(DEFAULT_TIMEOUT_CYCLES);

endpackage

// File: rtl/rom_sequencer_if.sv
// Control, LCD handshake and status bundle between the sequencer and its environment.
// Master drives run control and lcd_busy; slave (the sequencer) drives address and status.
interface rom_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int PASS_W = 8
);
  logic              start;
  logic              abort;
  logic              loop_mode;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              lcd_busy;
  logic [ADDR_W-1:0] rom_address;
  logic              data_ready;
  logic              active;
  logic              done;
  logic              timeout_err;
  logic [PASS_W-1:0] pass_count;

  modport master (
    output start, abort, loop_mode, start_addr, end_addr, lcd_busy,
    input  rom_address, data_ready, active, done, timeout_err, pass_count
  );

  modport slave (
    input  start, abort, loop_mode, start_addr, end_addr, lcd_busy,
    output rom_address, data_ready, active, done, timeout_err, pass_count
  );
endinterface

// File: rtl/rom_sequencer_busy_watchdog.sv
// Cycle counter that flags when PRESENT has waited TIMEOUT_CYCLES edges for lcd_busy.
// expired is combinational from the count; a TIMEOUT_CYCLES of 0 ties it low.
module busy_watchdog
  import rom_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic internal_reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = wdog_width(TIMEOUT_CYCLES);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_wdog;
      assign unused_wdog = ^{clock, internal_reset, clr, en};
      assign expired     = 1'b0;
    end else begin : g_on
      // The count equals cycles spent in PRESENT, so the last waiting cycle sees LIMIT.
      localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      assign expired = en && (cnt_q == LIMIT);

      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = '0;
        end else if (en && !expired) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clock or posedge internal_reset) begin
        if (internal_reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/rom_sequencer.sv
// Walks a ROM address window and hands each entry to the LCD over a busy-flag handshake.
// All outputs registered, 2 cycles minimum per entry; stalls on lcd_busy, watchdog escapes a stuck LCD.
module rom_sequencer
  import rom_seq_pkg::*;
#(
  parameter int          ADDR_W         = 4,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int          PASS_W         = 8
) (
  input logic             clock,
  input logic             internal_reset,
  rom_sequencer_if.slave  bus
);

  rom_seq_state_t    state_q,       state_d;
  logic [ADDR_W-1:0] addr_q,        addr_d;
  logic [ADDR_W-1:0] start_lat_q,   start_lat_d;
  logic [ADDR_W-1:0] end_lat_q,     end_lat_d;
  logic              loop_q,        loop_d;
  logic              data_ready_q,  data_ready_d;
  logic              active_q,      active_d;
  logic              done_q,        done_d;
  logic              timeout_err_q, timeout_err_d;
  logic [PASS_W-1:0] pass_q,        pass_d;

  logic wd_clr;
  logic wd_en;
  logic wd_expired;

  assign wd_en  = (state_q == PRESENT);
  assign wd_clr = (state_q != PRESENT);

  busy_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_busy_watchdog (
    .clock          (clock),
    .internal_reset (internal_reset),
    .clr            (wd_clr),
    .en             (wd_en),
    .expired        (wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    start_lat_d   = start_lat_q;
    end_lat_d     = end_lat_q;
    loop_d        = loop_q;
    data_ready_d  = data_ready_q;
    done_d        = done_q;
    timeout_err_d = timeout_err_q;
    pass_d        = pass_q;

    // Abort outranks everything; address and error flag are kept for inspection.
    if (bus.abort) begin
      state_d      = IDLE;
      data_ready_d = 1'b0;
      done_d       = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (bus.start) begin
            start_lat_d   = bus.start_addr;
            end_lat_d     = bus.end_addr;
            loop_d        = bus.loop_mode;
            addr_d        = bus.start_addr;
            done_d        = 1'b0;
            timeout_err_d = 1'b0;
            pass_d        = '0;
            state_d       = WAIT_FREE;
          end
        end
        WAIT_FREE: begin
          if (!bus.lcd_busy) begin
            data_ready_d = 1'b1;
            state_d      = PRESENT;
          end
        end
        PRESENT: begin
          if (wd_expired) begin
            data_ready_d  = 1'b0;
            timeout_err_d = 1'b1;
            state_d       = ERROR;
          end else if (bus.lcd_busy) begin
            data_ready_d = 1'b0;
            if (addr_q != end_lat_q) begin
              addr_d  = addr_q + 1'b1;
              state_d = WAIT_FREE;
            end else begin
              if (pass_q != {PASS_W{1'b1}}) begin
                pass_d = pass_q + 1'b1;
              end
              if (loop_q) begin
                addr_d  = start_lat_q;
                state_d = WAIT_FREE;
              end else begin
                addr_d  = '0;
                done_d  = 1'b1;
                state_d = DONE;
              end
            end
          end
        end
        default: begin
          data_ready_d = 1'b0;
          state_d      = IDLE;
        end
      endcase
    end

    active_d = (state_d == WAIT_FREE) || (state_d == PRESENT);
  end

  always_ff @(posedge clock or posedge internal_reset) begin
    if (internal_reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      start_lat_q   <= '0;
      end_lat_q     <= '0;
      loop_q        <= 1'b0;
      data_ready_q  <= 1'b0;
      active_q      <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      pass_q        <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      start_lat_q   <= start_lat_d;
      end_lat_q     <= end_lat_d;
      loop_q        <= loop_d;
      data_ready_q  <= data_ready_d;
      active_q      <= active_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      pass_q        <= pass_d;
    end
  end

  assign bus.rom_address = addr_q;
  assign bus.data_ready  = data_ready_q;
  assign bus.active      = active_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.pass_count  = pass_q;

endmodule

// File: tb/tb_rom_sequencer.sv
// Randomised bench for rom_sequencer: an LCD model answers each data_ready, and the
// presented address stream is compared with a window model built from modular arithmetic.
module tb_rom_sequencer;

  localparam int AW = 4;
  localparam int PW = 8;
  localparam int TO = 8;
  localparam int N  = 1 << AW;

  logic clock = 1'b0;
  logic internal_reset;
  int   checks = 0;
  int   errors = 0;
  int   obs_q[$];
  int   exp_q[$];

  rom_sequencer_if #(.ADDR_W(AW), .PASS_W(PW)) bus ();

  rom_sequencer #(
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TO),
    .PASS_W         (PW)
  ) dut (
    .clock          (clock),
    .internal_reset (internal_reset),
    .bus            (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1, "global time limit reached");
  end

  function automatic void build_exp(input int s, input int e, input int passes);
    int len = (((e - s) % N) + N) % N + 1;
    exp_q.delete();
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < len; i++)
        exp_q.push_back((s + i) % N);
  endfunction

  task automatic do_reset(input bit busy_lvl);
    internal_reset = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.loop_mode = 1'b0;
    bus.start_addr = '0; bus.end_addr = '0; bus.lcd_busy = busy_lvl;
    repeat (2) @(negedge clock);
    internal_reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic pulse_start(input int s, input int e, input bit lp);
    @(negedge clock);
    bus.start_addr = AW'(s); bus.end_addr = AW'(e); bus.loop_mode = lp; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    bus.start_addr = AW'($urandom); bus.end_addr = AW'($urandom); bus.loop_mode = 1'($urandom);
  endtask

  // LCD model: after a random delay, raise busy for 3 cycles per presented character.
  task automatic drive_lcd(input int stop_pulses, input int stuck_addr, input bit poke, input int budget);
    int busy_left = 0;
    int delay = $urandom_range(0, 3);
    int pulses = 0;
    bit prev_dr = 1'b0;
    bit ok = 1'b0;
    obs_q.delete();
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      bus.start = 1'b0;
      if (bus.data_ready && !prev_dr) begin
        obs_q.push_back(int'(bus.rom_address));
        pulses++;
        if (int'(bus.rom_address) == stuck_addr) begin ok = 1'b1; break; end
      end
      prev_dr = bus.data_ready;
      if (pulses >= stop_pulses && !bus.data_ready) begin ok = 1'b1; break; end
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) bus.lcd_busy = 1'b0;
      end else if (bus.data_ready) begin
        if (delay == 0) begin
          bus.lcd_busy = 1'b1; busy_left = 3; delay = $urandom_range(0, 3);
        end else delay--;
      end
      if (poke && $urandom_range(0, 5) == 0) begin
        bus.start = 1'b1; bus.start_addr = AW'($urandom);
        bus.end_addr = AW'($urandom); bus.loop_mode = 1'($urandom);
      end
    end
    bus.start = 1'b0;
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL lcd_run_budget: got %0d pulses in %0d cycles, required completion", pulses, budget);
    end
  endtask

  task automatic test_reset();
    internal_reset = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.loop_mode = 1'b0;
    bus.start_addr = '0; bus.end_addr = '0; bus.lcd_busy = 1'b0;
    #2;
    checks++; if (bus.rom_address !== '0) begin errors++; $display("FAIL reset_addr: got %0d required 0", bus.rom_address); end
    checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL reset_dr: got %b required 0", bus.data_ready); end
    checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b required 0", bus.active); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", bus.done); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b required 0", bus.timeout_err); end
    checks++; if (bus.pass_count !== '0) begin errors++; $display("FAIL reset_pass: got %0d required 0", bus.pass_count); end
    @(negedge clock); @(negedge clock);
    internal_reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (bus.active !== 1'b0 || bus.data_ready !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: active %b dr %b required 0 0", bus.active, bus.data_ready);
    end
  endtask

  task automatic test_full_window();
    bus.lcd_busy = 1'b0;
    pulse_start(0, N - 1, 1'b0);
    drive_lcd(N, -1, 1'b0, 2000);
    build_exp(0, N - 1, 1);
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL full_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_addr[%0d]: got %0d required %0d", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL full_done: got %b required 1", bus.done); end
    checks++; if (bus.pass_count !== PW'(1)) begin errors++; $display("FAIL full_pass: got %0d required 1", bus.pass_count); end
    checks++; if (bus.rom_address !== '0) begin errors++; $display("FAIL full_addr_end: got %0d required 0", bus.rom_address); end
    checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL full_active: got %b required 0", bus.active); end
  endtask

  task automatic test_wrap_loop();
    bus.lcd_busy = 1'b0;
    pulse_start(14, 1, 1'b1);
    drive_lcd(8, -1, 1'b1, 2000);
    build_exp(14, 1, 2);
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL wrap_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_addr[%0d]: got %0d required %0d", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (bus.pass_count !== PW'(2)) begin errors++; $display("FAIL wrap_pass: got %0d required 2", bus.pass_count); end
    checks++; if (bus.done !== 1'b0 || bus.active !== 1'b1) begin errors++; $display("FAIL wrap_running: done %b active %b required 0 1", bus.done, bus.active); end
    bus.abort = 1'b1;
    @(negedge clock);
    checks++; if (bus.active !== 1'b0 || bus.data_ready !== 1'b0) begin errors++; $display("FAIL wrap_abort: active %b dr %b required 0 0", bus.active, bus.data_ready); end
    checks++; if (bus.rom_address !== AW'(14)) begin errors++; $display("FAIL wrap_abort_addr: got %0d required 14", bus.rom_address); end
    bus.abort = 1'b0; bus.lcd_busy = 1'b0;
  endtask

  task automatic test_random_windows();
    for (int it = 0; it < 5; it++) begin
      int s = $urandom_range(0, N - 1);
      int e = $urandom_range(0, N - 1);
      bit lp = 1'($urandom);
      int passes = lp ? 2 : 1;
      int len = (((e - s) % N) + N) % N + 1;
      bus.lcd_busy = 1'b0;
      pulse_start(s, e, lp);
      drive_lcd(len * passes, -1, 1'b1, 4000);
      build_exp(s, e, passes);
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand%0d_count: got %0d required %0d", it, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_addr[%0d]: got %0d required %0d", it, i, obs_q[i], exp_q[i]); end
      end
      checks++; if (bus.pass_count !== PW'(passes)) begin errors++; $display("FAIL rand%0d_pass: got %0d required %0d", it, bus.pass_count, passes); end
      checks++; if (bus.done !== !lp) begin errors++; $display("FAIL rand%0d_done: got %b required %b", it, bus.done, !lp); end
      if (lp) begin
        bus.abort = 1'b1;
        @(negedge clock);
        bus.abort = 1'b0;
      end
      bus.lcd_busy = 1'b0;
    end
  endtask

  task automatic test_busy_at_start();
    int s = $urandom_range(0, N - 1);
    bit seen_dr = 1'b0;
    do_reset(1'b1);
    repeat (50) @(negedge clock);
    pulse_start(s, (s + 3) % N, 1'b0);
    checks++; if (bus.rom_address !== AW'(s) || bus.active !== 1'b1) begin
      errors++; $display("FAIL busy_start_addr: addr %0d active %b required %0d 1", bus.rom_address, bus.active, s);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (bus.data_ready) seen_dr = 1'b1;
    end
    checks++; if (seen_dr !== 1'b0) begin errors++; $display("FAIL busy_blocks: got data_ready while busy, required none"); end
    bus.lcd_busy = 1'b0;
    @(negedge clock);
    checks++; if (bus.data_ready !== 1'b1 || bus.rom_address !== AW'(s)) begin
      errors++; $display("FAIL busy_first: dr %b addr %0d required 1 %0d", bus.data_ready, bus.rom_address, s);
    end
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
  endtask

  task automatic test_timeout();
    bus.lcd_busy = 1'b0;
    pulse_start(2, 9, 1'b0);
    drive_lcd(100, 5, 1'b0, 2000);
    build_exp(2, 5, 1);
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL to_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL to_addr[%0d]: got %0d required %0d", i, obs_q[i], exp_q[i]); end
    end
    for (int k = 1; k < TO; k++) begin
      @(negedge clock);
      checks++; if (bus.timeout_err !== 1'b0 || bus.data_ready !== 1'b1) begin
        errors++; $display("FAIL to_early[%0d]: terr %b dr %b required 0 1", k, bus.timeout_err, bus.data_ready);
      end
    end
    @(negedge clock);
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag: got %b required 1", bus.timeout_err); end
    checks++; if (bus.data_ready !== 1'b0 || bus.active !== 1'b0) begin errors++; $display("FAIL to_outputs: dr %b active %b required 0 0", bus.data_ready, bus.active); end
    checks++; if (bus.rom_address !== AW'(5)) begin errors++; $display("FAIL to_addr_held: got %0d required 5", bus.rom_address); end
    repeat (3) @(negedge clock);
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b required 1", bus.timeout_err); end
    pulse_start(7, 7, 1'b0);
    checks++; if (bus.timeout_err !== 1'b0 || bus.rom_address !== AW'(7)) begin
      errors++; $display("FAIL to_restart: terr %b addr %0d required 0 7", bus.timeout_err, bus.rom_address);
    end
    drive_lcd(1, -1, 1'b0, 200);
    checks++; if (bus.done !== 1'b1 || bus.pass_count !== PW'(1)) begin
      errors++; $display("FAIL single_entry: done %b pass %0d required 1 1", bus.done, bus.pass_count);
    end
  endtask

  task automatic test_abort_on_rise();
    bus.lcd_busy = 1'b0;
    pulse_start(0, 7, 1'b0);
    drive_lcd(100, 3, 1'b0, 2000);
    bus.lcd_busy = 1'b1; bus.abort = 1'b1;
    @(negedge clock);
    checks++; if (bus.data_ready !== 1'b0 || bus.active !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL abort_outputs: dr %b active %b done %b required 0 0 0", bus.data_ready, bus.active, bus.done);
    end
    checks++; if (bus.rom_address !== AW'(3)) begin errors++; $display("FAIL abort_addr: got %0d required 3", bus.rom_address); end
    checks++; if (bus.pass_count !== '0) begin errors++; $display("FAIL abort_pass: got %0d required 0", bus.pass_count); end
    bus.abort = 1'b0; bus.lcd_busy = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (bus.active !== 1'b0 || bus.data_ready !== 1'b0) begin
      errors++; $display("FAIL abort_stays_idle: active %b dr %b required 0 0", bus.active, bus.data_ready);
    end
  endtask

  task automatic test_async_reset();
    bus.lcd_busy = 1'b0;
    pulse_start(4, 5, 1'b1);
    drive_lcd(2, -1, 1'b0, 500);
    bus.lcd_busy = 1'b0;
    @(negedge clock);
    checks++; if (bus.data_ready !== 1'b1 || bus.pass_count !== PW'(1)) begin
      errors++; $display("FAIL pre_reset: dr %b pass %0d required 1 1", bus.data_ready, bus.pass_count);
    end
    #2 internal_reset = 1'b1;
    #1;
    checks++; if (bus.rom_address !== '0 || bus.data_ready !== 1'b0 || bus.active !== 1'b0) begin
      errors++; $display("FAIL async_reset_a: addr %0d dr %b active %b required 0 0 0", bus.rom_address, bus.data_ready, bus.active);
    end
    checks++; if (bus.done !== 1'b0 || bus.timeout_err !== 1'b0 || bus.pass_count !== '0) begin
      errors++; $display("FAIL async_reset_b: done %b terr %b pass %0d required 0 0 0", bus.done, bus.timeout_err, bus.pass_count);
    end
    @(negedge clock);
    internal_reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL post_reset_idle: active %b required 0", bus.active); end
  endtask

  initial begin
    test_reset();
    test_full_window();
    test_wrap_loop();
    test_random_windows();
    test_busy_at_start();
    test_timeout();
    test_abort_on_rise();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
